// File: rtl/conv_pkg.sv
// Shared types and default widths for the ID1000500A convolution engine.
package conv_pkg;

   localparam int DEF_DATA_W = 32;  // X, Y, Z word width
   localparam int DEF_AXY_W  = 5;   // X/Y address width, also width of the sample counts
   localparam int DEF_AZ_W   = 6;   // Z address width

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      READ,
      MAC,
      WRITE,
      DONE
   } state_e;

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate register: acc <= acc + a*b, everything modulo 2^DATA_W.
module conv_mac
   import conv_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_a,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] acc
);

   // Only the low DATA_W bits of the product are kept, so overflow wraps.
   logic [DATA_W-1:0] prod;
   assign prod = a * b;

   // Accumulator: clear at the start of each output word, add one term per MAC cycle.
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod;
      end
   end

endmodule

// File: rtl/id1000500a_conv_core.sv
// Convolution core: Z[k] = sum_i X[i]*Y[k-i], read from two synchronous ROM-style
// memories (1-cycle read latency) and written word by word into the Z memory.
module id1000500a_conv_core
   import conv_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int AXY_W  = DEF_AXY_W,
   parameter int AZ_W   = DEF_AZ_W
) (
   input  logic              clk,
   input  logic              rst_a,
   input  logic              start,
   input  logic [AXY_W-1:0]  size_x,
   input  logic [AXY_W-1:0]  size_y,
   output logic [AXY_W-1:0]  x_addr,
   input  logic [DATA_W-1:0] x_data,
   output logic [AXY_W-1:0]  y_addr,
   input  logic [DATA_W-1:0] y_data,
   output logic [AZ_W-1:0]   z_addr,
   output logic [DATA_W-1:0] z_data,
   output logic              z_we,
   output logic              busy,
   output logic              done
);

   state_e            state, state_nxt;
   logic [AXY_W-1:0]  sx_q, sy_q;      // sizes latched on start
   logic [AZ_W-1:0]   k_q;             // output index
   logic [AXY_W-1:0]  i_q, i_hi_q;     // current term and last term for this k
   logic [AZ_W-1:0]   sy_m1, k_last;
   logic [AXY_W-1:0]  i_lo, i_hi;
   logic              last_term, last_k;
   logic [DATA_W-1:0] acc;

   // Valid i range for the current k: max(0, k-sy+1) .. min(k, sx-1).
   assign sy_m1     = AZ_W'(sy_q) - AZ_W'(1);
   assign k_last    = AZ_W'(sx_q) + sy_m1 - AZ_W'(1);
   assign i_lo      = (k_q > sy_m1) ? AXY_W'(k_q - sy_m1) : '0;
   assign i_hi      = (k_q < AZ_W'(sx_q)) ? AXY_W'(k_q) : sx_q - AXY_W'(1);
   assign last_term = (i_q == i_hi_q);
   assign last_k    = (k_q == k_last);

   // State register.
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a start outside IDLE is ignored.
   // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (size_x == '0 || size_y == '0) ? DONE : SETUP;
         SETUP:   state_nxt = READ;
         READ:    state_nxt = MAC;
         MAC:     state_nxt = last_term ? WRITE : READ;
         WRITE:   state_nxt = last_k ? DONE : SETUP;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Sizes, counters and read addresses. Addresses are registered so they are
   // already valid during READ and simply hold their value everywhere else.
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         sx_q   <= '0;
         sy_q   <= '0;
         k_q    <= '0;
         i_q    <= '0;
         i_hi_q <= '0;
         x_addr <= '0;
         y_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sx_q <= size_x;
                  sy_q <= size_y;
                  k_q  <= '0;
               end
            end
            SETUP: begin
               i_q    <= i_lo;
               i_hi_q <= i_hi;
               x_addr <= i_lo;
               y_addr <= AXY_W'(k_q - AZ_W'(i_lo));
            end
            MAC: begin
               i_q <= i_q + AXY_W'(1);
               // Next term: i rises by one, so k-i falls by one.
               if (!last_term) begin
                  x_addr <= i_q + AXY_W'(1);
                  y_addr <= y_addr - AXY_W'(1);
               end
            end
            WRITE: begin
               k_q <= k_q + AZ_W'(1);
            end
            default: ;
         endcase
      end
   end

   conv_mac #(
      .DATA_W (DATA_W)
   ) u_mac (
      .clk   (clk),
      .rst_a (rst_a),
      .clr   (state == SETUP),
      .en    (state == MAC),
      .a     (x_data),
      .b     (y_data),
      .acc   (acc)
   );

   // Z port is driven only while writing; zero otherwise.
   assign z_we   = (state == WRITE);
   assign z_addr = z_we ? k_q : '0;
   assign z_data = z_we ? acc : '0;
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);

endmodule

// File: tb/tb_id1000500a_conv_core.sv
// Scoreboard bench for the convolution core: stimulus pushes expected Z writes and
// done cycles into queues, a negedge monitor pops and compares them.
module tb_id1000500a_conv_core;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
   } zexp_t;

   logic        clk = 1'b0;
   logic        rst_a = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  size_x = '0;
   logic [4:0]  size_y = '0;
   logic [4:0]  x_addr, y_addr;
   logic [31:0] x_data = '0;
   logic [31:0] y_data = '0;
   logic [5:0]  z_addr;
   logic [31:0] z_data;
   logic        z_we, busy, done;

   logic [31:0] x_mem [32];
   logic [31:0] y_mem [32];
   logic [31:0] z_mem [64];

   zexp_t z_q [$];
   int    done_q [$];

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int base = 0;
   int done_cnt = 0;
   int start_done = 0;
   int busy_cnt = 0;

   id1000500a_conv_core dut (
      .clk    (clk),
      .rst_a  (rst_a),
      .start  (start),
      .size_x (size_x),
      .size_y (size_y),
      .x_addr (x_addr),
      .x_data (x_data),
      .y_addr (y_addr),
      .y_data (y_data),
      .z_addr (z_addr),
      .z_data (z_data),
      .z_we   (z_we),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   // X/Y synchronous ROMs, Z write-capture array, edge counter.
   always @(posedge clk) begin
      x_data   <= x_mem[x_addr];
      y_data   <= y_mem[y_addr];
      edge_cnt <= edge_cnt + 1;
      if (z_we) z_mem[z_addr] <= z_data;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // Monitor: compare every Z write and every done pulse against the queues.
   always @(negedge clk) begin : mon
      int    cyc;
      zexp_t e;
      cyc = edge_cnt - base + 1;
      if (rst_a === 1'b0) busy_cnt = 0;
      else if (busy === 1'b1) busy_cnt++;
      if (z_we === 1'b1) begin
         if (z_q.size() == 0) begin
            fail_now("z_we_unexpected");
         end else begin
            e = z_q.pop_front();
            check("z_addr", z_addr, e.addr);
            check("z_data", z_data, e.data);
         end
      end
      if (done === 1'b1) begin
         done_cnt++;
         if (done_q.size() == 0) begin
            fail_now("done_unexpected");
         end else begin
            check("done_cycle", cyc, done_q.pop_front());
            check("busy_cycles", busy_cnt, cyc);
         end
         busy_cnt = 0;
      end
   end

   task automatic push_z(input logic [5:0] a, input logic [31:0] d);
      zexp_t e;
      e.addr = a;
      e.data = d;
      z_q.push_back(e);
   endtask

   // Reference convolution for the first nk output words.
   task automatic push_model(input int sx, input int sy, input int nk);
      for (int k = 0; k < nk; k++) begin
         logic [31:0] s;
         s = '0;
         for (int i = 0; i < sx; i++) begin
            if (k - i >= 0 && k - i < sy) s = s + x_mem[i] * y_mem[k - i];
         end
         push_z(6'(k), s);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < 32; i++) begin
         x_mem[i] = $urandom;
         y_mem[i] = $urandom;
      end
   endtask

   // Start sampled at the edge after the first negedge; that edge is "edge 0".
   task automatic start_run(input logic [4:0] sx, input logic [4:0] sy);
      @(negedge clk);
      size_x     = sx;
      size_y     = sy;
      start      = 1'b1;
      base       = edge_cnt + 1;
      start_done = done_cnt;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cnt == start_done && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (done_cnt == start_done) begin
         fail_now("done_timeout");
      end else begin
         @(negedge clk);
         #1;
         check("busy_after_done", busy, 1'b0);
         check("pending_writes", z_q.size(), 0);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_z_we"}, z_we, 1'b0);
      check({tag, "_z_addr"}, z_addr, 6'd0);
      check({tag, "_z_data"}, z_data, 32'd0);
      check({tag, "_x_addr"}, x_addr, 5'd0);
      check({tag, "_y_addr"}, y_addr, 5'd0);
   endtask

   initial begin
      fill_random();
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_a = 1'b1;
      @(negedge clk);

      // 1x1: Z[0] = 3*4, done in cycle 5.
      x_mem[0] = 32'd3;
      y_mem[0] = 32'd4;
      push_z(6'd0, 32'd12);
      done_q.push_back(5);
      start_run(5'd1, 5'd1);
      wait_done(50);

      // 10x5 random data: 14 words, done in cycle 129.
      fill_random();
      push_model(10, 5, 14);
      done_q.push_back(129);
      start_run(5'd10, 5'd5);
      wait_done(300);

      // Zero sizes: no writes, done in cycle 1.
      done_q.push_back(1);
      start_run(5'd0, 5'd5);
      wait_done(20);
      done_q.push_back(1);
      start_run(5'd3, 5'd0);
      wait_done(20);

      // Wrap-around: FFFFFFFF*2 = FFFFFFFE, 2*2 = 4, done in cycle 9.
      x_mem[0] = 32'hFFFF_FFFF;
      x_mem[1] = 32'd2;
      y_mem[0] = 32'd2;
      push_z(6'd0, 32'hFFFF_FFFE);
      push_z(6'd1, 32'd4);
      done_q.push_back(9);
      start_run(5'd2, 5'd1);
      wait_done(50);
      check("z_mem0", z_mem[0], 32'hFFFF_FFFE);
      check("z_mem1", z_mem[1], 32'd4);

      // Second start and size change mid-run must not disturb the run.
      fill_random();
      push_model(10, 5, 14);
      done_q.push_back(129);
      start_run(5'd10, 5'd5);
      repeat (20) @(negedge clk);
      size_x = 5'd3;
      size_y = 5'd2;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_done(300);
      repeat (10) @(negedge clk);
      check("single_done", done_cnt, start_done + 1);

      // Reset at the start of cycle 40: words 0..3 are out, k=4 not yet written.
      fill_random();
      push_model(10, 5, 4);
      start_run(5'd10, 5'd5);
      repeat (39) @(posedge clk);
      #1;
      rst_a = 1'b0;
      #1;
      check_outputs_zero("abort");
      check("writes_before_reset", z_q.size(), 0);
      repeat (3) @(negedge clk);
      rst_a = 1'b1;
      repeat (5) @(negedge clk);
      check("no_done_after_abort", done_cnt, start_done);

      // Full run after the abort.
      fill_random();
      push_model(10, 5, 14);
      done_q.push_back(129);
      start_run(5'd10, 5'd5);
      wait_done(300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "time limit");
   end

endmodule
